// File: rtl/posit_mac_accum.sv
`default_nettype none
// posit_mac_accum -- exact posit products summed into a quire-style fixed-point accumulator.
// Rev 1.0
module posit_mac_accum #(
  parameter  int WIDTH = 8,
  parameter  int EXP   = 2,
  parameter  int GUARD = 8,
  localparam int REGI  = $clog2(WIDTH) + 1,
  localparam int MTS   = WIDTH - 3 - EXP,
  localparam int QFRAC = 2 * (WIDTH - 2) * (2 ** EXP),
  localparam int QINT  = QFRAC + 2,
  localparam int ACCW  = 1 + QINT + QFRAC + GUARD
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vld_i,
  input  logic              last_i,
  input  logic              sign_a_i,
  input  logic              sign_b_i,
  input  logic [REGI-1:0]   regi_a_i,
  input  logic [REGI-1:0]   regi_b_i,
  input  logic [EXP-1:0]    exp_a_i,
  input  logic [EXP-1:0]    exp_b_i,
  input  logic [MTS-1:0]    mts_a_i,
  input  logic [MTS-1:0]    mts_b_i,
  input  logic [1:0]        cls_a_i,
  input  logic [1:0]        cls_b_i,
  output logic [ACCW-1:0]   acc_o,
  output logic              acc_vld_o,
  output logic [GUARD:0]    cnt_o,
  output logic              nar_o,
  output logic              ovf_o
);

  localparam int SW = REGI + EXP + 2;
  localparam int PW = 2 * MTS + 2;
  localparam int CW = GUARD + 1;
  localparam logic [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

  // stage 1: scale and mantissa product
  logic signed [SW-1:0] rsum;
  logic signed [SW-1:0] scale_in;
  logic [PW-1:0]        mprod_in;

  always_comb begin
    rsum     = SW'($signed(regi_a_i)) + SW'($signed(regi_b_i));
    scale_in = (rsum <<< EXP) + $signed(SW'(exp_a_i)) + $signed(SW'(exp_b_i));
    mprod_in = PW'({1'b1, mts_a_i}) * PW'({1'b1, mts_b_i});
  end

  logic                 s1_vld;
  logic                 s1_last;
  logic                 s1_sign;
  logic                 s1_zero;
  logic                 s1_nar;
  logic signed [SW-1:0] s1_scale;
  logic [PW-1:0]        s1_mprod;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_nar   <= 1'b0;
      s1_scale <= '0;
      s1_mprod <= '0;
    end else begin
      s1_vld   <= vld_i;
      s1_last  <= vld_i & last_i;
      s1_sign  <= sign_a_i ^ sign_b_i;
      s1_zero  <= (cls_a_i == 2'b00) || (cls_b_i == 2'b00);
      s1_nar   <= cls_a_i[1] | cls_b_i[1];
      s1_scale <= scale_in;
      s1_mprod <= mprod_in;
    end
  end

  // stage 2: align the product so that bit 0 carries weight 2^-QFRAC
  logic signed [31:0] sh;
  logic [ACCW-1:0]    mag;
  logic [ACCW-1:0]    term_in;

  always_comb begin
    sh = 32'(s1_scale) + 32'(QFRAC - 2 * MTS);
    if (sh >= 0) begin
      mag = ACCW'(s1_mprod) << sh;
    end else begin
      mag = ACCW'(s1_mprod) >> (-sh);
    end
    term_in = s1_sign ? (-mag) : mag;
    if (s1_zero || s1_nar) begin
      term_in = '0;
    end
  end

  logic            s2_vld;
  logic            s2_last;
  logic            s2_nar;
  logic [ACCW-1:0] s2_term;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      s2_nar  <= 1'b0;
      s2_term <= '0;
    end else begin
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
      s2_nar  <= s1_nar;
      s2_term <= term_in;
    end
  end

  // stage 3: saturating accumulate with one extra bit to detect signed overflow
  logic [ACCW-1:0] acc;
  logic [CW-1:0]   cnt;
  logic            nar_st;
  logic            ovf_st;
  logic [ACCW:0]   sum;
  logic            beat_ovf;
  logic [ACCW-1:0] acc_next;
  logic [CW-1:0]   cnt_next;

  always_comb begin
    sum      = {acc[ACCW-1], acc} + {s2_term[ACCW-1], s2_term};
    beat_ovf = sum[ACCW] ^ sum[ACCW-1];
    acc_next = sum[ACCW-1:0];
    if (beat_ovf) begin
      acc_next = sum[ACCW] ? ACC_MIN : ACC_MAX;
    end
    cnt_next = (&cnt) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc       <= '0;
      cnt       <= '0;
      nar_st    <= 1'b0;
      ovf_st    <= 1'b0;
      acc_o     <= '0;
      acc_vld_o <= 1'b0;
      cnt_o     <= '0;
      nar_o     <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      acc_vld_o <= 1'b0;
      if (s2_vld) begin
        if (s2_last) begin
          // report the closing group and start the next one from zero on the same edge
          acc_o     <= (nar_st | s2_nar) ? '0 : acc_next;
          cnt_o     <= cnt_next;
          nar_o     <= nar_st | s2_nar;
          ovf_o     <= ovf_st | beat_ovf;
          acc_vld_o <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          nar_st    <= 1'b0;
          ovf_st    <= 1'b0;
        end else begin
          acc    <= acc_next;
          cnt    <= cnt_next;
          nar_st <= nar_st | s2_nar;
          ovf_st <= ovf_st | beat_ovf;
        end
      end
    end
  end

endmodule
`default_nettype wire
